// File: rtl/wt_dcache_ctrl_pkg.sv
// Shared widths, request/response payloads and cacheable-region helper for the
// write-through L1 dcache read controller.
package wt_dcache_ctrl_pkg;

   localparam int unsigned PLEN                = 56;
   localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
   localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
   localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
   localparam int unsigned DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
   localparam int unsigned DCACHE_SET_ASSOC    = 8;
   localparam int unsigned CACHE_ID_WIDTH      = 3;

   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [63:0]                   data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [7:0]                    data_be;
      logic [1:0]                    data_size;
      logic                          kill_req;
      logic                          tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;

   // Single cacheable region: [base, base + length)
   typedef struct packed {
      logic [63:0] CachedRegionAddrBase;
      logic [63:0] CachedRegionLength;
   } ariane_cfg_t;

   localparam ariane_cfg_t ArianeDefaultConfig = '{
      CachedRegionAddrBase: 64'h0000_0000_8000_0000,
      CachedRegionLength:   64'h0000_0000_4000_0000
   };

   function automatic logic is_inside_cacheable_regions(ariane_cfg_t cfg, logic [63:0] addr);
      return (addr >= cfg.CachedRegionAddrBase) &&
             (addr < (cfg.CachedRegionAddrBase + cfg.CachedRegionLength));
   endfunction

endpackage

// File: rtl/wt_dcache_ctrl.sv
// Read controller for one load-type port of the write-through L1 dcache: tag
// lookup through the shared memory read port, miss handoff and data return.
module wt_dcache_ctrl
   import wt_dcache_ctrl_pkg::*;
#(
   parameter logic [CACHE_ID_WIDTH-1:0] RdTxId    = CACHE_ID_WIDTH'(1),
   parameter ariane_cfg_t               ArianeCfg = ArianeDefaultConfig
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           cache_en_i,
   input  dcache_req_i_t                  req_port_i,
   output dcache_req_o_t                  req_port_o,
   output logic                           miss_req_o,
   input  logic                           miss_ack_i,
   output logic                           miss_we_o,
   output logic [63:0]                    miss_wdata_o,
   output logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_o,
   output logic [PLEN-1:0]                miss_paddr_o,
   output logic                           miss_nc_o,
   output logic [2:0]                     miss_size_o,
   output logic [CACHE_ID_WIDTH-1:0]      miss_id_o,
   input  logic                           miss_replay_i,
   input  logic                           miss_rtrn_vld_i,
   input  logic                           wr_cl_vld_i,
   output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
   output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
   output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
   output logic                           rd_req_o,
   output logic                           rd_tag_only_o,
   input  logic                           rd_ack_i,
   input  logic [63:0]                    rd_data_i,
   input  logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_i,
   input  logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_i
);

   typedef enum logic [2:0] {
      IDLE, READ, MISS_REQ, MISS_WAIT, KILL_MISS, KILL_MISS_ACK, REPLAY_REQ, REPLAY_READ
   } state_e;

   state_e                          state_q, state_d;
   logic [DCACHE_INDEX_WIDTH-1:0]   idx_q, idx_d;
   logic [DCACHE_TAG_WIDTH-1:0]     tag_q, tag_d;
   logic [1:0]                      size_q;
   logic [DCACHE_SET_ASSOC-1:0]     vld_q;
   logic                            rd_ack_q;

   logic gnt_c, rvalid_c, save_tag_c, hit_c, resolve_c;
   logic unused_c;

   assign hit_c     = (|rd_hit_oh_i) && cache_en_i;
   assign resolve_c = req_port_i.tag_valid || (state_q == REPLAY_READ);

   assign idx_d = gnt_c      ? req_port_i.address_index : idx_q;
   assign tag_d = save_tag_c ? req_port_i.address_tag   : tag_q;

   assign rd_tag_o      = tag_d;
   assign rd_idx_o      = idx_d[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
   assign rd_off_o      = idx_d[DCACHE_OFFSET_WIDTH-1:0];
   assign rd_tag_only_o = 1'b0;

   assign miss_we_o       = 1'b0;
   assign miss_wdata_o    = 64'h0;
   assign miss_vld_bits_o = vld_q;
   assign miss_paddr_o    = {tag_q, idx_q};
   assign miss_size_o     = {1'b0, size_q};
   assign miss_id_o       = RdTxId;
   assign miss_nc_o       = ~cache_en_i | ~is_inside_cacheable_regions(ArianeCfg, 64'({tag_q, idx_q}));

   assign req_port_o = '{data_gnt: gnt_c, data_rvalid: rvalid_c, data_rdata: rd_data_i};

   // Write-side fields of the shared request type have no meaning on a read port
   assign unused_c = ^{req_port_i.data_wdata, req_port_i.data_we, req_port_i.data_be};

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_port_i.data_req && rd_ack_i) state_d = READ;
         end
         READ, REPLAY_READ: begin
            if (req_port_i.kill_req) begin
               state_d = IDLE;
            end else if (resolve_c) begin
               if (wr_cl_vld_i || !rd_ack_q) state_d = REPLAY_REQ;
               else if (hit_c)                state_d = (req_port_i.data_req && rd_ack_i) ? READ : IDLE;
               else                           state_d = MISS_REQ;
            end
         end
         MISS_REQ: begin
            if (req_port_i.kill_req) state_d = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
            else if (miss_replay_i)  state_d = REPLAY_REQ;
            else if (miss_ack_i)     state_d = MISS_WAIT;
         end
         MISS_WAIT: begin
            if (miss_rtrn_vld_i)          state_d = IDLE;
            else if (req_port_i.kill_req) state_d = KILL_MISS;
         end
         REPLAY_REQ: begin
            if (req_port_i.kill_req) state_d = IDLE;
            else if (rd_ack_i)       state_d = REPLAY_READ;
         end
         KILL_MISS_ACK: begin
            if (miss_replay_i)   state_d = IDLE;
            else if (miss_ack_i) state_d = KILL_MISS;
         end
         KILL_MISS: begin
            if (miss_rtrn_vld_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic; a killed request gets its rvalid immediately, its miss return is swallowed later
   always_comb begin
      rd_req_o   = 1'b0;
      miss_req_o = 1'b0;
      gnt_c      = 1'b0;
      rvalid_c   = 1'b0;
      save_tag_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_port_i.data_req) begin
               rd_req_o = 1'b1;
               gnt_c    = rd_ack_i;
            end
         end
         READ, REPLAY_READ: begin
            rd_req_o   = 1'b1;
            save_tag_c = (state_q == READ) && req_port_i.tag_valid;
            if (req_port_i.kill_req) begin
               rvalid_c = 1'b1;
            end else if (resolve_c && !wr_cl_vld_i && rd_ack_q && hit_c) begin
               rvalid_c = 1'b1;
               gnt_c    = req_port_i.data_req && rd_ack_i;
            end
         end
         MISS_REQ: begin
            miss_req_o = 1'b1;
            rvalid_c   = req_port_i.kill_req;
         end
         MISS_WAIT: begin
            rvalid_c = miss_rtrn_vld_i || req_port_i.kill_req;
         end
         REPLAY_REQ: begin
            rd_req_o = 1'b1;
            rvalid_c = req_port_i.kill_req;
         end
         KILL_MISS_ACK: begin
            miss_req_o = 1'b1;
         end
         default: ;
      endcase
   end

   // Request context captured at grant / tag compare
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q    <= '0;
         tag_q    <= '0;
         size_q   <= '0;
         vld_q    <= '0;
         rd_ack_q <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         tag_q    <= tag_d;
         rd_ack_q <= rd_ack_i;
         if (gnt_c)      size_q <= req_port_i.data_size;
         if (save_tag_c) vld_q  <= rd_vld_bits_i;
      end
   end

endmodule

// File: tb/tb_wt_dcache_ctrl.sv
// Directed bench for wt_dcache_ctrl: hit, miss, collision replay, kill,
// cache-disable, back-to-back hits and reset in the middle of a miss.
module tb_wt_dcache_ctrl;
   import wt_dcache_ctrl_pkg::*;

   logic                           clk, rst_ni, cache_en;
   dcache_req_i_t                  req;
   dcache_req_o_t                  rsp;
   logic                           miss_req, miss_ack, miss_we, miss_nc, miss_replay, miss_rtrn;
   logic [63:0]                    miss_wdata;
   logic [DCACHE_SET_ASSOC-1:0]    miss_vld, rd_vld, rd_hit;
   logic [PLEN-1:0]                miss_paddr;
   logic [2:0]                     miss_size;
   logic [CACHE_ID_WIDTH-1:0]      miss_id;
   logic                           wr_cl, rd_req, rd_tag_only, rd_ack;
   logic [DCACHE_TAG_WIDTH-1:0]    rd_tag;
   logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx;
   logic [DCACHE_OFFSET_WIDTH-1:0] rd_off;
   logic [63:0]                    rd_data;

   int n_vec = 0;
   int n_err = 0;

   wt_dcache_ctrl #(.RdTxId(CACHE_ID_WIDTH'(1))) dut (
      .clk_i(clk), .rst_ni(rst_ni), .cache_en_i(cache_en),
      .req_port_i(req), .req_port_o(rsp),
      .miss_req_o(miss_req), .miss_ack_i(miss_ack), .miss_we_o(miss_we),
      .miss_wdata_o(miss_wdata), .miss_vld_bits_o(miss_vld), .miss_paddr_o(miss_paddr),
      .miss_nc_o(miss_nc), .miss_size_o(miss_size), .miss_id_o(miss_id),
      .miss_replay_i(miss_replay), .miss_rtrn_vld_i(miss_rtrn), .wr_cl_vld_i(wr_cl),
      .rd_tag_o(rd_tag), .rd_idx_o(rd_idx), .rd_off_o(rd_off), .rd_req_o(rd_req),
      .rd_tag_only_o(rd_tag_only), .rd_ack_i(rd_ack), .rd_data_i(rd_data),
      .rd_vld_bits_i(rd_vld), .rd_hit_oh_i(rd_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clr();
      req         = '0;
      miss_ack    = 1'b0;
      miss_replay = 1'b0;
      miss_rtrn   = 1'b0;
      wr_cl       = 1'b0;
      rd_ack      = 1'b0;
      rd_hit      = '0;
      rd_vld      = '0;
      rd_data     = 64'h0;
   endtask

   // Inputs change on the falling edge; outputs are checked 1ns later
   task automatic nxt();
      @(negedge clk);
      clr();
   endtask

   task automatic do_grant(input logic [11:0] idx, input logic [1:0] sz);
      nxt();
      req.data_req      = 1'b1;
      req.address_index = idx;
      req.data_size     = sz;
      rd_ack            = 1'b1;
      #1;
      chk("gnt", 64'(rsp.data_gnt), 64'd1);
      chk("gnt_rvalid", 64'(rsp.data_rvalid), 64'd0);
   endtask

   task automatic go_miss(input logic [43:0] tag);
      nxt();
      req.tag_valid   = 1'b1;
      req.address_tag = tag;
      rd_vld          = 8'h5A;
      #1;
      chk("miss_cmp_rvalid", 64'(rsp.data_rvalid), 64'd0);
   endtask

   initial begin
      clk = 1'b0; rst_ni = 1'b0; cache_en = 1'b1;
      clr();
      #3;
      chk("rst_rd_req", 64'(rd_req), 64'd0);
      chk("rst_miss_req", 64'(miss_req), 64'd0);
      chk("rst_rvalid", 64'(rsp.data_rvalid), 64'd0);
      chk("rst_paddr", 64'(miss_paddr), 64'd0);
      chk("tag_only", 64'(rd_tag_only), 64'd0);
      chk("miss_we", 64'({miss_we, miss_wdata != 64'h0}), 64'd0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Hit
      do_grant(12'h040, 2'b11);
      chk("hit_rd_idx", 64'(rd_idx), 64'h04);
      chk("hit_rd_off", 64'(rd_off), 64'h0);
      nxt(); req.tag_valid = 1'b1; req.address_tag = 44'h80000; rd_hit = 8'h01; rd_data = 64'hDEAD; #1;
      chk("hit_rvalid", 64'(rsp.data_rvalid), 64'd1);
      chk("hit_rdata", rsp.data_rdata, 64'hDEAD);
      chk("hit_rd_tag", 64'(rd_tag), 64'h80000);
      chk("hit_no_gnt", 64'(rsp.data_gnt), 64'd0);
      nxt(); #1;
      chk("hit_idle_rvalid", 64'(rsp.data_rvalid), 64'd0);
      chk("hit_idle_rd_req", 64'(rd_req), 64'd0);

      // Miss
      do_grant(12'h040, 2'b11);
      go_miss(44'h80000);
      nxt(); miss_ack = 1'b1; #1;
      chk("miss_req", 64'(miss_req), 64'd1);
      chk("miss_paddr", 64'(miss_paddr), 64'h8000_0040);
      chk("miss_id", 64'(miss_id), 64'd1);
      chk("miss_nc", 64'(miss_nc), 64'd0);
      chk("miss_vld", 64'(miss_vld), 64'h5A);
      chk("miss_size", 64'(miss_size), 64'd3);
      chk("miss_req_rvalid", 64'(rsp.data_rvalid), 64'd0);
      nxt(); #1;
      chk("miss_wait_rvalid", 64'(rsp.data_rvalid), 64'd0);
      chk("miss_wait_req", 64'(miss_req), 64'd0);
      nxt(); miss_rtrn = 1'b1; rd_data = 64'hBEEF; #1;
      chk("miss_rtrn_rvalid", 64'(rsp.data_rvalid), 64'd1);
      chk("miss_rtrn_rdata", rsp.data_rdata, 64'hBEEF);
      nxt(); #1;
      chk("miss_idle_rvalid", 64'(rsp.data_rvalid), 64'd0);

      // Collision with line write -> replay, single rvalid, no re-grant
      do_grant(12'h100, 2'b00);
      nxt(); req.tag_valid = 1'b1; req.address_tag = 44'h80001; rd_hit = 8'h01; wr_cl = 1'b1; #1;
      chk("col_rvalid", 64'(rsp.data_rvalid), 64'd0);
      nxt(); req.data_req = 1'b1; rd_ack = 1'b1; #1;
      chk("rpl_rd_req", 64'(rd_req), 64'd1);
      chk("rpl_no_gnt", 64'(rsp.data_gnt), 64'd0);
      chk("rpl_rvalid0", 64'(rsp.data_rvalid), 64'd0);
      nxt(); rd_hit = 8'h01; rd_data = 64'h1234; #1;
      chk("rpl_rvalid", 64'(rsp.data_rvalid), 64'd1);
      chk("rpl_no_gnt2", 64'(rsp.data_gnt), 64'd0);
      chk("rpl_rd_tag", 64'(rd_tag), 64'h80001);
      chk("rpl_rd_idx", 64'(rd_idx), 64'h10);
      nxt(); #1;
      chk("rpl_idle_rvalid", 64'(rsp.data_rvalid), 64'd0);

      // Kill in MISS_REQ before ack: rvalid now, return swallowed later
      do_grant(12'h040, 2'b01);
      go_miss(44'h80000);
      nxt(); req.kill_req = 1'b1; #1;
      chk("kill_rvalid", 64'(rsp.data_rvalid), 64'd1);
      chk("kill_miss_req", 64'(miss_req), 64'd1);
      nxt(); miss_ack = 1'b1; #1;
      chk("kma_miss_req", 64'(miss_req), 64'd1);
      chk("kma_rvalid", 64'(rsp.data_rvalid), 64'd0);
      nxt(); #1;
      chk("km_miss_req", 64'(miss_req), 64'd0);
      chk("km_rvalid", 64'(rsp.data_rvalid), 64'd0);
      nxt(); miss_rtrn = 1'b1; #1;
      chk("km_rtrn_rvalid", 64'(rsp.data_rvalid), 64'd0);

      // Cache disabled: hit treated as non-cacheable miss
      cache_en = 1'b0;
      do_grant(12'h040, 2'b00);
      nxt(); req.tag_valid = 1'b1; req.address_tag = 44'h80000; rd_hit = 8'h01; #1;
      chk("dis_rvalid", 64'(rsp.data_rvalid), 64'd0);
      nxt(); miss_ack = 1'b1; #1;
      chk("dis_miss_req", 64'(miss_req), 64'd1);
      chk("dis_nc", 64'(miss_nc), 64'd1);
      nxt(); #1;
      nxt(); miss_rtrn = 1'b1; #1;
      chk("dis_rtrn_rvalid", 64'(rsp.data_rvalid), 64'd1);
      cache_en = 1'b1;

      // Back-to-back hits with data_req held
      do_grant(12'h040, 2'b00);
      for (int i = 0; i < 3; i++) begin
         nxt();
         req.tag_valid = 1'b1; req.address_tag = 44'h80000; rd_hit = 8'h01;
         rd_data = 64'(i + 16'hA0); req.data_req = 1'b1; rd_ack = 1'b1;
         req.address_index = 12'(12'h080 + i * 16);
         #1;
         chk("b2b_rvalid", 64'(rsp.data_rvalid), 64'd1);
         chk("b2b_gnt", 64'(rsp.data_gnt), 64'd1);
         chk("b2b_rdata", rsp.data_rdata, 64'(i + 16'hA0));
         chk("b2b_rd_idx", 64'(rd_idx), 64'(8 + i));
      end
      nxt(); req.tag_valid = 1'b1; rd_hit = 8'h01; #1;
      chk("b2b_last_rvalid", 64'(rsp.data_rvalid), 64'd1);
      chk("b2b_last_gnt", 64'(rsp.data_gnt), 64'd0);
      nxt(); #1;
      chk("b2b_idle_rvalid", 64'(rsp.data_rvalid), 64'd0);

      // Asynchronous reset in the middle of a miss
      do_grant(12'h040, 2'b00);
      go_miss(44'h80000);
      nxt(); miss_ack = 1'b1; #1;
      chk("rm_miss_req", 64'(miss_req), 64'd1);
      nxt(); #2; rst_ni = 1'b0; #1;
      chk("rm_paddr", 64'(miss_paddr), 64'd0);
      chk("rm_vld", 64'(miss_vld), 64'd0);
      chk("rm_rvalid", 64'(rsp.data_rvalid), 64'd0);
      chk("rm_miss_req0", 64'(miss_req), 64'd0);
      nxt(); rst_ni = 1'b1; #1;
      chk("rm_idle_rd_req", 64'(rd_req), 64'd0);
      do_grant(12'h040, 2'b00);
      nxt(); req.tag_valid = 1'b1; req.address_tag = 44'h80000; rd_hit = 8'h01; rd_data = 64'h77; #1;
      chk("rm_hit_rvalid", 64'(rsp.data_rvalid), 64'd1);
      nxt(); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
